arith_seq_unit: RTL



---
 rtl/arith_seq_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/arith_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arith_seq_unit: handshaked unsigned add/sub/mul (1 cycle) and restoring div |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module arith_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_value_a,
    input  logic [WIDTH-1:0] i_value_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_aux,
    output logic             o_carry,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_trial;
    logic               step_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   dvd_next;

    assign o_ready  = (state == S_IDLE) && reset_n;

    // Zero-extended subtraction: the top bit of the difference is the borrow.
    assign add_full = {1'b0, i_value_a} + {1'b0, i_value_b};
    assign sub_full = {1'b0, i_value_a} - {1'b0, i_value_b};
    assign mul_full = {{WIDTH{1'b0}}, i_value_a} * {{WIDTH{1'b0}}, i_value_b};

    // rem < divisor always holds, so the shifted value is below 2*divisor and a
    // negative trial difference always shows up in its top bit.
    assign rem_shift = {rem, dvd[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, divisor};
    assign step_ge   = ~rem_trial[WIDTH];
    assign rem_next  = step_ge ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign dvd_next  = {dvd[WIDTH-2:0], step_ge};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_aux         <= '0;
            o_carry       <= 1'b0;
            o_div_by_zero <= 1'b0;
            divisor       <= '0;
            dvd           <= '0;
            rem           <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (i_op == 2'b11 && i_value_b != '0) begin
                            divisor <= i_value_b;
                            dvd     <= i_value_a;
                            rem     <= '0;
                            cnt     <= CW'(WIDTH);
                            state   <= S_DIV;
                        end else begin
                            state         <= S_DONE;
                            o_valid       <= 1'b1;
                            o_aux         <= '0;
                            o_carry       <= 1'b0;
                            o_div_by_zero <= 1'b0;
                            case (i_op)
                                2'b00: {o_carry, o_result} <= add_full;
                                2'b01: begin
                                    o_result <= sub_full[WIDTH-1:0];
                                    o_carry  <= sub_full[WIDTH];
                                end
                                2'b10: begin
                                    {o_aux, o_result} <= mul_full;
                                    o_carry           <= (mul_full[2*WIDTH-1:WIDTH] != '0);
                                end
                                default: begin
                                    o_result      <= '1;
                                    o_aux         <= i_value_a;
                                    o_div_by_zero <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_DIV: begin
                    rem <= rem_next;
                    dvd <= dvd_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        o_result      <= dvd_next;
                        o_aux         <= rem_next;
                        o_carry       <= 1'b0;
                        o_div_by_zero <= 1'b0;
                        o_valid       <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
